// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Multi-cycle sequencer for the EX-stage MULTU/MADDU unit and the HI/LO
//   register pair. A request runs an unsigned shift-add multiply, one
//   multiplier bit per cycle, then writes (MULTU) or accumulates (MADDU) the
//   2*WIDTH-bit product into HI:LO. While the sequencer is busy, a new
//   MULT/MADD/MFHI/MFLO in EX raises a stall so the pipeline holds it.
//
//   Optional feature: define MULT_EARLY_TERM_EN to end the MUL phase as soon
//   as the remaining multiplier bits are all zero. Without it, the MUL phase
//   always runs WIDTH iterations and no early-exit compare is built.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   multu_req  in   1      MULTU in EX this cycle
//   maddu_req  in   1      MADDU in EX this cycle (wins if both requests set)
//   hilo_rd    in   1      MFHI/MFLO in EX this cycle
//   dataA      in   WIDTH  rs operand (multiplicand)
//   dataB      in   WIDTH  rt operand (multiplier)
//   busy       out  1      sequencer not IDLE
//   stall      out  1      hold IF/ID, ID/EX, PC; bubble into EX/MEM
//   done       out  1      one-cycle pulse: HI/LO just updated
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multu_req,
  input  logic             maddu_req,
  input  logic             hilo_rd,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             req;
  logic             last_iter;

  // HI:LO update at commit; the sum wraps modulo 2^(2*WIDTH).
  function automatic logic [PW-1:0] hilo_update(input logic          acc,
                                                input logic [PW-1:0] hilo,
                                                input logic [PW-1:0] prod);
    if (acc) return hilo + prod;
    else     return prod;
  endfunction

  assign req   = multu_req | maddu_req;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (req | hilo_rd);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    last_iter = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          mcand_d  = {{WIDTH{1'b0}}, dataA};
          mplier_d = dataB;
          prod_d   = '0;
          cnt_d    = '0;
          // Simultaneous MULTU+MADDU behaves as MADDU.
          acc_d    = maddu_req;
          state_d  = S_MUL;
        end
      end

      // Iteration boundary: one multiplier bit consumed per cycle.
      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
        // No set bits left means the remaining iterations would add nothing.
        if (mplier_d == '0) last_iter = 1'b1;
`endif
        if (last_iter) state_d = S_COMMIT;
      end

      // Commit boundary: HI/LO written, done pulses next cycle.
      S_COMMIT: begin
        {hi_d, lo_d} = hilo_update(acc_q, {hi_q, lo_q}, prod_q);
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl (WIDTH=32). Expected HI:LO values are computed
// by a bench-side model and pushed to a scoreboard when each request is
// driven; they are popped and compared whenever the DUT pulses done.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         multu_req, maddu_req, hilo_rd;
  logic [W-1:0] dataA, dataB;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] sb_q[$];
  logic [63:0] hilo_m = 64'd0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .multu_req (multu_req),
    .maddu_req (maddu_req),
    .hilo_rd   (hilo_rd),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Iteration count the sequencer should take for a given multiplier.
  function automatic int n_of(input logic [W-1:0] b);
    int n;
`ifdef MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Push the expected result for an accepted request and advance the model.
  task automatic push_exp(input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    hilo_m = acc ? hilo_m + p : p;
    sb_q.push_back(hilo_m);
  endtask

  // op: 0 = MULTU, 1 = MADDU, 2 = both requests set (behaves as MADDU).
  task automatic run_op(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, first_busy, last_busy, done_cyc, unstable;
    logic [63:0] hilo_before;
    n = n_of(b);
    first_busy = -1; last_busy = -1; done_cyc = -1; unstable = 0;
    @(negedge clk);
    hilo_before = {hi, lo};
    multu_req = (op != 1);
    maddu_req = (op != 0);
    hilo_rd   = 1'b1;
    dataA = a; dataB = b;
    push_exp(op != 0, a, b);
    #1;
    check({tag, "_stall_idle"}, {63'd0, stall}, 64'd0);
    for (int k = 1; k <= W + 10; k++) begin
      @(negedge clk);
      multu_req = 1'b0; maddu_req = 1'b0; hilo_rd = 1'b0;
      #1;
      if (busy) begin
        if (first_busy < 0) first_busy = k;
        last_busy = k;
        if ({hi, lo} !== hilo_before) unstable++;
      end
      if (done && done_cyc < 0) done_cyc = k;
    end
    check({tag, "_first_busy"}, 64'(first_busy), 64'd1);
    check({tag, "_last_busy"},  64'(last_busy),  64'(n + 1));
    check({tag, "_done_cycle"}, 64'(done_cyc),   64'(n + 2));
    check({tag, "_hilo_stable"}, 64'(unstable),  64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    int n1, n2, acc2, stall_err, busy_err, dcount;
    logic eb, es;

    reset = 1'b1; multu_req = 1'b0; maddu_req = 1'b0; hilo_rd = 1'b0;
    dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    run_op("mul3x5", 0, 32'd3, 32'd5);
    run_op("madd2x3", 1, 32'd2, 32'd3);
    run_op("mulmax", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("madd_a", 1, 32'hFFFF_FFFE, 32'd1);
    run_op("madd_b", 2, 32'h0001_0000, 32'h0001_0000);
    run_op("madd_wrap", 1, 32'd1, 32'd1);
    run_op("mul7x0", 0, 32'd7, 32'd0);
    run_op("mul_pat", 0, 32'hDEAD_BEEF, 32'h8000_0001);

    // Stall behaviour: MFHI/MFLO and a second MULTU held while busy.
    a1 = 32'hFFFF_FFFF; b1 = 32'h1234_5678;
    a2 = 32'h0000_ABCD; b2 = 32'h0000_0103;
    n1 = n_of(b1); n2 = n_of(b2);
    acc2 = (n1 + 2 > 10) ? n1 + 2 : 10;
    stall_err = 0; busy_err = 0;
    @(negedge clk);
    multu_req = 1'b1; dataA = a1; dataB = b1;
    push_exp(1'b0, a1, b1);
    for (int k = 1; k <= acc2 + n2 + 6; k++) begin
      @(negedge clk);
      multu_req = (k >= 10 && k <= acc2);
      hilo_rd   = (k >= 5 && k <= 40);
      if (k >= 10) begin dataA = a2; dataB = b2; end
      if (k == 10) push_exp(1'b0, a2, b2);
      #1;
      eb = (k <= n1 + 1) || (k >= acc2 + 1 && k <= acc2 + n2 + 1);
      es = eb && (hilo_rd || multu_req);
      if (busy !== eb) busy_err++;
      if (stall !== es) stall_err++;
      if (k == acc2) begin
        check("t4_stall_release", {63'd0, stall}, 64'd0);
        check("t4_lo_at_release", {32'd0, lo}, {32'd0, a1 * b1});
      end
    end
    multu_req = 1'b0; hilo_rd = 1'b0;
    check("t4_busy_trace", 64'(busy_err), 64'd0);
    check("t4_stall_trace", 64'(stall_err), 64'd0);

    // Reset in the middle of a multiply aborts it with no done pulse.
    @(negedge clk);
    multu_req = 1'b1; dataA = 32'd9; dataB = 32'hFFFF_0000;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      multu_req = 1'b0;
      reset = (k == 10);
    end
    #1;
    hilo_m = 64'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);

    run_op("madd_after_rst", 1, 32'h0000_1234, 32'h0000_5678);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
